// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension stage: mode encodings,
// SHAMT field location and the default 32-bit entry layout.
package imm_pkg;

  localparam int unsigned IMM_ZERO   = 0;
  localparam int unsigned IMM_SIGN   = 1;
  localparam int unsigned IMM_LUI    = 2;
  localparam int unsigned IMM_SHAMT  = 3;
  localparam int unsigned IMM_BRANCH = 4;

  localparam int unsigned SHAMT_LO = 6;
  localparam int unsigned SHAMT_HI = 10;

  localparam int unsigned DEF_DATA_WIDTH = 32;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] imm_out;
    logic [DEF_DATA_WIDTH-1:0] br_target;
    logic                      illegal;
  } imm_entry_t;

endpackage

// File: rtl/imm_ext_stage_if.sv
// Decode-side and EX-side handshake/data signals of the immediate-extension stage.
interface imm_ext_stage_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMM_WIDTH  = 16,
  parameter int unsigned MODE_WIDTH = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IMM_WIDTH-1:0]  imm;
  logic [MODE_WIDTH-1:0] mode;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] imm_out;
  logic [DATA_WIDTH-1:0] br_target;
  logic                  illegal_mode;

  modport master (
    output in_valid, imm, mode, pc_plus4, out_ready,
    input  in_ready, out_valid, imm_out, br_target, illegal_mode
  );

  modport slave (
    input  in_valid, imm, mode, pc_plus4, out_ready,
    output in_ready, out_valid, imm_out, br_target, illegal_mode
  );
endinterface

// File: rtl/imm_ext_core.sv
// Combinational extender: turns a raw immediate, mode and PC+4 into one
// pipeline entry (extended value, branch target, reserved-mode flag).
module imm_ext_core
  import imm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMM_WIDTH  = 16,
  parameter int unsigned MODE_WIDTH = 3,
  parameter type         entry_t    = imm_entry_t
) (
  input  logic [IMM_WIDTH-1:0]  imm,
  input  logic [MODE_WIDTH-1:0] mode,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  output entry_t                entry
);

  localparam int unsigned PAD = DATA_WIDTH - IMM_WIDTH;
  localparam int unsigned SHAMT_W = SHAMT_HI - SHAMT_LO + 1;

  logic [DATA_WIDTH-1:0] signExt;
  logic [DATA_WIDTH-1:0] ext;
  logic                  isBranch;
  logic                  illegal;

  assign signExt = {{PAD{imm[IMM_WIDTH-1]}}, imm};

  always_comb begin
    ext      = '0;
    illegal  = 1'b0;
    isBranch = 1'b0;
    case (mode)
      MODE_WIDTH'(IMM_ZERO):   ext = {{PAD{1'b0}}, imm};
      MODE_WIDTH'(IMM_SIGN):   ext = signExt;
      MODE_WIDTH'(IMM_LUI):    ext = {imm, {PAD{1'b0}}};
      MODE_WIDTH'(IMM_SHAMT):  ext = {{(DATA_WIDTH-SHAMT_W){1'b0}}, imm[SHAMT_HI:SHAMT_LO]};
      MODE_WIDTH'(IMM_BRANCH): begin
        // Word offset: the top two sign bits fall off, the bottom two become zero.
        ext      = {signExt[DATA_WIDTH-3:0], 2'b00};
        isBranch = 1'b1;
      end
      default:                 illegal = 1'b1;
    endcase
  end

  always_comb begin
    entry           = '0;
    entry.imm_out   = ext;
    entry.br_target = isBranch ? pc_plus4 + ext : pc_plus4;
    entry.illegal   = illegal;
  end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage: extender core feeding a 2-entry skid
// buffer so ID keeps issuing for one cycle after EX stalls.
module imm_ext_stage
  import imm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IMM_WIDTH  = 16,
  parameter int unsigned MODE_WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  imm_ext_stage_if.slave   bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] imm_out;
    logic [DATA_WIDTH-1:0] br_target;
    logic                  illegal;
  } entry_t;

  entry_t coreEntry;
  entry_t mainQ;
  entry_t skidQ;
  logic   mainV;
  logic   skidV;
  logic   accept;
  logic   drain;

  imm_ext_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMM_WIDTH  (IMM_WIDTH),
    .MODE_WIDTH (MODE_WIDTH),
    .entry_t    (entry_t)
  ) uCore (
    .imm      (bus.imm),
    .mode     (bus.mode),
    .pc_plus4 (bus.pc_plus4),
    .entry    (coreEntry)
  );

  // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
  assign accept = bus.in_valid & ~skidV;
  assign drain  = mainV & bus.out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mainV <= 1'b0;
      skidV <= 1'b0;
      mainQ <= '0;
      skidQ <= '0;
    end else if (flush) begin
      mainV <= 1'b0;
      skidV <= 1'b0;
    end else if (!mainV || drain) begin
      if (skidV) begin
        mainQ <= skidQ;
        mainV <= 1'b1;
        skidV <= 1'b0;
      end else if (accept) begin
        mainQ <= coreEntry;
        mainV <= 1'b1;
      end else begin
        mainV <= 1'b0;
      end
    end else if (accept) begin
      skidQ <= coreEntry;
      skidV <= 1'b1;
    end
  end

  assign bus.in_ready     = ~skidV;
  assign bus.out_valid    = mainV;
  assign bus.imm_out      = mainQ.imm_out;
  assign bus.br_target    = mainQ.br_target;
  assign bus.illegal_mode = mainQ.illegal;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Self-checking bench for imm_ext_stage: directed scenarios plus a random
// run, all scored against an in-order queue model of the stage.
module tb_imm_ext_stage;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] br;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  imm_ext_stage_if #(.DATA_WIDTH(32), .IMM_WIDTH(16), .MODE_WIDTH(3)) bus ();

  imm_ext_stage #(.DATA_WIDTH(32), .IMM_WIDTH(16), .MODE_WIDTH(3)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic exp_t refModel(input logic [15:0] imm, input logic [2:0] mode,
                                    input logic [31:0] pc);
    exp_t r;
    int   s;
    s = int'($signed(imm));
    r.illegal = 1'b0;
    r.br = pc;
    case (mode)
      3'd0: r.imm = 32'(imm);
      3'd1: r.imm = s;
      3'd2: r.imm = {imm, 16'h0000};
      3'd3: r.imm = 32'((imm / 64) % 32);
      3'd4: begin r.imm = s * 4; r.br = pc + r.imm; end
      default: begin r.imm = 32'h0; r.illegal = 1'b1; end
    endcase
    return r;
  endfunction

  task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] i,
                       input logic [31:0] pc, input logic ordy);
    bus.in_valid  = v;
    bus.mode      = m;
    bus.imm       = i;
    bus.pc_plus4  = pc;
    bus.out_ready = ordy;
  endtask

  // One clock: score outputs at the falling edge, then advance the model.
  task automatic cycle();
    logic expV, expR, acc, dr;
    exp_t e;
    @(negedge clk);
    expV = (q.size() != 0);
    expR = (q.size() < 2);
    checks++;
    if (bus.out_valid !== expV) begin
      errors++; $display("FAIL out_valid got %b want %b", bus.out_valid, expV);
    end
    checks++;
    if (bus.in_ready !== expR) begin
      errors++; $display("FAIL in_ready got %b want %b", bus.in_ready, expR);
    end
    if (expV && bus.out_valid === 1'b1) begin
      checks++;
      if (bus.imm_out !== q[0].imm || bus.br_target !== q[0].br ||
          bus.illegal_mode !== q[0].illegal) begin
        errors++;
        $display("FAIL entry got %h/%h/%b want %h/%h/%b", bus.imm_out, bus.br_target,
                 bus.illegal_mode, q[0].imm, q[0].br, q[0].illegal);
      end
    end
    acc = bus.in_valid && expR;
    dr  = bus.out_ready && expV;
    e   = refModel(bus.imm, bus.mode, bus.pc_plus4);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (dr) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 3'd0, 16'h0, 32'h0, 1'b1);
    reset = 1'b1;
    q.delete();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.imm_out !== 32'h0 ||
        bus.br_target !== 32'h0 || bus.illegal_mode !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b r=%b imm=%h br=%h ill=%b want 0 1 0 0 0",
               bus.out_valid, bus.in_ready, bus.imm_out, bus.br_target, bus.illegal_mode);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sign();
    drive(1'b1, 3'd1, 16'h8000, 32'h00400004, 1'b1);
    cycle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.imm_out !== 32'hFFFF8000 ||
        bus.br_target !== 32'h00400004 || bus.illegal_mode !== 1'b0) begin
      errors++;
      $display("FAIL sign got v=%b imm=%h br=%h ill=%b want 1 FFFF8000 00400004 0",
               bus.out_valid, bus.imm_out, bus.br_target, bus.illegal_mode);
    end
    drive(1'b0, 3'd0, 16'h0, 32'h0, 1'b1);
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  m[3]   = '{3'd0, 3'd2, 3'd3};
    logic [15:0] im[3]  = '{16'hFFFF, 16'h1234, 16'h0140};
    logic [31:0] ex[3]  = '{32'h0000FFFF, 32'h12340000, 32'h00000005};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, m[i], im[i], 32'h1000, 1'b1);
      cycle();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.imm_out !== ex[i]) begin
        errors++;
        $display("FAIL b2b_%0d got v=%b imm=%h want 1 %h", i, bus.out_valid, bus.imm_out, ex[i]);
      end
    end
    drive(1'b0, 3'd0, 16'h0, 32'h0, 1'b1);
    cycle();
  endtask

  task automatic test_branch();
    drive(1'b1, 3'd4, 16'hFFFF, 32'h00000004, 1'b1);
    cycle();
    checks++;
    if (bus.imm_out !== 32'hFFFFFFFC || bus.br_target !== 32'h00000000) begin
      errors++;
      $display("FAIL branch_neg got imm=%h br=%h want FFFFFFFC 00000000", bus.imm_out, bus.br_target);
    end
    drive(1'b1, 3'd4, 16'h0001, 32'hFFFFFFFC, 1'b1);
    cycle();
    checks++;
    if (bus.imm_out !== 32'h00000004 || bus.br_target !== 32'h00000000) begin
      errors++;
      $display("FAIL branch_wrap got imm=%h br=%h want 00000004 00000000", bus.imm_out, bus.br_target);
    end
    drive(1'b0, 3'd0, 16'h0, 32'h0, 1'b1);
    cycle();
  endtask

  task automatic test_stall();
    drive(1'b1, 3'd0, 16'h00AA, 32'h0, 1'b0);
    cycle();
    drive(1'b1, 3'd1, 16'hFF00, 32'h0, 1'b0);
    cycle();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.imm_out !== 32'h000000AA) begin
      errors++;
      $display("FAIL stall_full got r=%b v=%b imm=%h want 0 1 000000AA",
               bus.in_ready, bus.out_valid, bus.imm_out);
    end
    drive(1'b1, 3'd2, 16'h5555, 32'h0, 1'b0);
    cycle();
    drive(1'b0, 3'd0, 16'h0, 32'h0, 1'b1);
    cycle();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || bus.imm_out !== 32'hFFFFFF00) begin
      errors++;
      $display("FAIL stall_drain got r=%b v=%b imm=%h want 1 1 FFFFFF00",
               bus.in_ready, bus.out_valid, bus.imm_out);
    end
    cycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL stall_empty got v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 3'd0, 16'h0011, 32'h0, 1'b0);
    cycle();
    drive(1'b1, 3'd0, 16'h0022, 32'h0, 1'b0);
    cycle();
    drive(1'b1, 3'd0, 16'h0033, 32'h0, 1'b0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush got v=%b r=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    drive(1'b0, 3'd0, 16'h0, 32'h0, 1'b1);
    repeat (2) cycle();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_ghost got v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_illegal_async_reset();
    drive(1'b1, 3'd6, 16'h1234, 32'h00000100, 1'b0);
    cycle();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.imm_out !== 32'h0 || bus.illegal_mode !== 1'b1 ||
        bus.br_target !== 32'h00000100) begin
      errors++;
      $display("FAIL illegal got v=%b imm=%h br=%h ill=%b want 1 0 00000100 1",
               bus.out_valid, bus.imm_out, bus.br_target, bus.illegal_mode);
    end
    drive(1'b0, 3'd0, 16'h0, 32'h0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got v=%b r=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    q.delete();
    #1 reset = 1'b0;
    @(posedge clk); #1;
    cycle();
  endtask

  task automatic test_random();
    logic [31:0] pc;
    for (int n = 0; n < 500; n++) begin
      pc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom), pc,
            $urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      cycle();
    end
    flush = 1'b0;
    drive(1'b0, 3'd0, 16'h0, 32'h0, 1'b1);
    repeat (3) cycle();
  endtask

  initial begin
    test_reset();
    test_sign();
    test_back_to_back();
    test_branch();
    test_stall();
    test_flush();
    test_illegal_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_ext_stage.md
Name: imm_ext_stage

Overview:
- Registered, parametrised immediate-extension stage for the pipelined MIPS datapath. It sits between ID decode and the EX operand muxes.
- Generalises zero/sign/LUI extension to a mode-selected extender covering ZERO, SIGN, LUI, SHAMT and BRANCH. It also computes the branch target.
- Results are held in a 2-entry skid buffer with a valid/ready handshake and a synchronous flush, so the stage decouples decode from EX stalls.

Parameters:
- DATA_WIDTH, 32, datapath width. Must be >= IMM_WIDTH+3.
- IMM_WIDTH, 16, raw immediate field width. Must be >= 11 so SHAMT bits [10:6] exist.
- MODE_WIDTH, 3, width of the mode select.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline flush (branch mispredict / exception).
- in_valid  in  1  upstream holds a valid immediate.
- in_ready  out  1  stage can accept this cycle.
- imm  in  IMM_WIDTH  raw immediate field.
- mode  in  MODE_WIDTH  extension mode (encodings in package).
- pc_plus4  in  DATA_WIDTH  PC+4 of the instruction.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- imm_out  out  DATA_WIDTH  extended immediate.
- br_target  out  DATA_WIDTH  branch target.
- illegal_mode  out  1  flags that the output entry was produced from a reserved mode.

Behaviour:
- Reset (async): main_v=0, skid_v=0, out_valid=0, in_ready=1, imm_out=0, br_target=0, illegal_mode=0. All data registers are cleared.
- Mode encodings and results (E = the computed result):
  - 0 ZERO: E = {0s, imm}.
  - 1 SIGN: E = {imm[IMM_WIDTH-1] replicated, imm}.
  - 2 LUI: E = {imm, (DATA_WIDTH-IMM_WIDTH) zeros}, truncated to DATA_WIDTH.
  - 3 SHAMT: E = zero-extended imm[10:6].
  - 4 BRANCH: E = sign-extended imm shifted left 2. Upper bits are sign-filled; the shift drops the top 2 bits beyond DATA_WIDTH.
  - 5-7 reserved: E = 0, and illegal=1 is stored with the entry.
- br_target:
  - mode BRANCH: pc_plus4 + E, modulo 2^DATA_WIDTH (wrap-around, no carry out).
  - All other modes: pc_plus4.
- Latency: 1 cycle from accept to out_valid when the main register is empty. Full throughput of 1 entry per cycle while out_ready=1.
- in_ready = ~skid_v. It is driven from a register, with no combinational path from out_ready.
- accept = in_valid & in_ready. drain = out_valid & out_ready.
- Main register loads when it is empty or drain occurs:
  - If skid_v: main gets the skid contents, skid_v goes to 0.
  - Else if accept: main gets the freshly computed entry.
  - Else: main_v goes to 0.
- Skid register: loads on accept when main_v=1 and out_ready=0. This requires skid_v=0, which in_ready guarantees.
- Ordering: entries leave in strict acceptance order. The skid entry is always older than any later input.
- Outputs: out_valid = main_v. imm_out, br_target and illegal_mode are the main register fields, held stable while out_valid & ~out_ready.
- flush: on the next edge main_v=0 and skid_v=0. An accept in the same cycle is discarded. Flush overrides drain and accept. in_ready=1 the cycle after.
- Reset mid-operation: all entries are lost immediately (async). No output glitch persists past deassertion.
- Data fields of invalid entries may hold stale values. The bench checks them only when out_valid=1.

Decomposition:
- Package imm_pkg:
  - Mode localparams IMM_ZERO=0, IMM_SIGN=1, IMM_LUI=2, IMM_SHAMT=3, IMM_BRANCH=4.
  - An entry struct {imm_out, br_target, illegal}.
  - SHAMT_LO=6, SHAMT_HI=10.
- Sub-module imm_ext_core (combinational): takes imm, mode and pc_plus4 and produces the entry struct.
- imm_ext_stage holds the skid-buffer control and registers only.

Test Plan:
- reset=1, then deassert; mode=SIGN, imm=16'h8000, pc_plus4=32'h00400004, out_ready=1 -> next cycle out_valid=1, imm_out=32'hFFFF8000, br_target=32'h00400004, illegal_mode=0.
- Back-to-back, out_ready=1:
  - ZERO 16'hFFFF -> 32'h0000FFFF.
  - LUI 16'h1234 -> 32'h12340000.
  - SHAMT 16'h0140 -> 32'h00000005.
  - Required: one result per cycle, in order.
- BRANCH imm=16'hFFFF, pc_plus4=32'h00000004 -> imm_out=32'hFFFFFFFC, br_target=32'h00000000. Also BRANCH imm=16'h0001, pc_plus4=32'hFFFFFFFC -> br_target=32'h00000000 (wrap).
- Stall: out_ready=0, send A then B -> in_ready=0 the cycle after B is accepted, out_valid=1 showing A. Raise out_ready -> A then B are output, and in_ready returns to 1.
- With both entries full, assert flush with in_valid=1 -> next cycle out_valid=0 and in_ready=1. The flushed and same-cycle inputs never appear.
- mode=6, imm=16'h1234 -> imm_out=0, illegal_mode=1. Assert async reset while out_valid=1 -> out_valid=0 immediately, without waiting for a clk edge.
